mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 64 ++++++
 rtl/mc_outdec.sv | 69 ++++++
 rtl/mc_control.sv | 123 ++++++++++++
 tb/tb_mc_control.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit:
// state numbers, opcode constants and the datapath control word.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_HALT   = 4'd15
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [1:0] ALUB_REG  = 2'b00;
   localparam logic [1:0] ALUB_FOUR = 2'b01;
   localparam logic [1:0] ALUB_IMM  = 2'b10;
   localparam logic [1:0] ALUB_BOFS = 2'b11;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_OUT  = 2'b01;
   localparam logic [1:0] PCSRC_JUMP = 2'b10;

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   // States that finish an instruction unconditionally on their single cycle.
   function automatic logic is_final(input state_t s);
      return (s == S_MEMWB) || (s == S_ALUWB) || (s == S_BRANCH) ||
             (s == S_JUMP)  || (s == S_ADDIWB);
   endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decode: maps the current state to its base control word.
// Handshake/flag qualification of PC and IR enables happens in the top.
module mc_outdec
   import mc_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = CTRL_IDLE;
      unique case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_en     = 1'b1;
            ctrl.alu_src_b = ALUB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
         end
         S_DECODE: begin
            ctrl.alu_src_b = ALUB_BOFS;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_REG;
            ctrl.alu_op    = ALUOP_FUNC;
         end
         S_ALUWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_REG;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.pc_source = PCSRC_OUT;
            ctrl.pc_en     = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_source = PCSRC_JUMP;
            ctrl.pc_en     = 1'b1;
         end
         S_ADDIWB: begin
            ctrl.reg_write = 1'b1;
         end
         default: ctrl = CTRL_IDLE;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM with registered retire/illegal pulses
// and a wrapping retired-instruction counter.
module mc_control
   import mc_pkg::*;
#(
   parameter bit TRAP_ILLEGAL = 1'b0,
   parameter int CNT_W        = 32
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [5:0]       Opcode,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             PCEn,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic [3:0]       State,
   output logic             Retire,
   output logic             Illegal,
   output logic [CNT_W-1:0] InstrCount
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t     state;
   ctrl_t      ctrl;
   logic       pc_qual;
   logic       retire;
   logic       illegal;
   logic [CNT_W-1:0] count;

   mc_outdec u_outdec (
      .state (state),
      .ctrl  (ctrl)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= S_FETCH;
         retire  <= 1'b0;
         illegal <= 1'b0;
         count   <= '0;
      end else begin
         retire  <= 1'b0;
         illegal <= 1'b0;
         if (is_final(state)) begin
            retire <= 1'b1;
            count  <= count + ONE;
            state  <= S_FETCH;
         end else begin
            unique case (state)
               S_FETCH: begin
                  if (MemReady) state <= S_DECODE;
               end
               S_DECODE: begin
                  unique case (Opcode)
                     OP_R:         state <= S_EXEC;
                     OP_LW, OP_SW: state <= S_MEMADR;
                     OP_BEQ:       state <= S_BRANCH;
                     OP_J:         state <= S_JUMP;
                     OP_ADDI:      state <= S_ADDIEX;
                     default: begin
                        illegal <= 1'b1;
                        state   <= TRAP_ILLEGAL ? S_HALT : S_FETCH;
                     end
                  endcase
               end
               S_MEMADR: begin
                  state <= (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
               end
               S_MEMRD: begin
                  if (MemReady) state <= S_MEMWB;
               end
               S_MEMWR: begin
                  if (MemReady) begin
                     retire <= 1'b1;
                     count  <= count + ONE;
                     state  <= S_FETCH;
                  end
               end
               S_EXEC:   state <= S_ALUWB;
               S_ADDIEX: state <= S_ADDIWB;
               S_HALT:   state <= S_HALT;
               default:  state <= S_FETCH;
            endcase
         end
      end
   end

   // FETCH commits PC/IR only on a completed read; BRANCH only when taken.
   always_comb begin
      pc_qual = 1'b1;
      if (state == S_FETCH)  pc_qual = MemReady;
      if (state == S_BRANCH) pc_qual = Zero;
   end

   assign PCEn       = ctrl.pc_en & pc_qual;
   assign IRWrite    = ctrl.ir_write & MemReady;
   assign IorD       = ctrl.iord;
   assign MemRead    = ctrl.mem_read;
   assign MemWrite   = ctrl.mem_write;
   assign RegDst     = ctrl.reg_dst;
   assign MemtoReg   = ctrl.mem_to_reg;
   assign RegWrite   = ctrl.reg_write;
   assign ALUSrcA    = ctrl.alu_src_a;
   assign ALUSrcB    = ctrl.alu_src_b;
   assign ALUOp      = ctrl.alu_op;
   assign PCSource   = ctrl.pc_source;
   assign State      = state;
   assign Retire     = retire;
   assign Illegal    = illegal;
   assign InstrCount = count;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: one non-trapping 4-bit-counter instance
// and one trapping instance driven by the same stimulus.
module tb_mc_control;

   logic       Clk;
   logic       Reset_n;
   logic [5:0] Opcode;
   logic       Zero;
   logic       MemReady;

   logic       PCEn, IorD, MemRead, MemWrite, IRWrite;
   logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] State;
   logic       Retire, Illegal;
   logic [3:0] InstrCount;

   logic       t_PCEn, t_IorD, t_MemRead, t_MemWrite, t_IRWrite;
   logic       t_RegDst, t_MemtoReg, t_RegWrite, t_ALUSrcA;
   logic [1:0] t_ALUSrcB, t_ALUOp, t_PCSource;
   logic [3:0] t_State;
   logic       t_Retire, t_Illegal;
   logic [7:0] t_InstrCount;

   int vectors;
   int miscompares;

   mc_control #(.TRAP_ILLEGAL(1'b0), .CNT_W(4)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .Zero(Zero),
      .MemReady(MemReady), .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .State(State), .Retire(Retire), .Illegal(Illegal),
      .InstrCount(InstrCount)
   );

   mc_control #(.TRAP_ILLEGAL(1'b1), .CNT_W(8)) dut_trap (
      .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .Zero(Zero),
      .MemReady(MemReady), .PCEn(t_PCEn), .IorD(t_IorD),
      .MemRead(t_MemRead), .MemWrite(t_MemWrite), .IRWrite(t_IRWrite),
      .RegDst(t_RegDst), .MemtoReg(t_MemtoReg), .RegWrite(t_RegWrite),
      .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB), .ALUOp(t_ALUOp),
      .PCSource(t_PCSource), .State(t_State), .Retire(t_Retire),
      .Illegal(t_Illegal), .InstrCount(t_InstrCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      Reset_n  = 1'b0;
      Opcode   = 6'b000000;
      Zero     = 1'b0;
      MemReady = 1'b1;
      #2;
      chk("rst_state", State, 4'd0);
      chk("rst_count", InstrCount, 4'd0);
      chk("rst_retire", Retire, 1'b0);
      chk("rst_illegal", Illegal, 1'b0);
      @(negedge Clk);
      Reset_n = 1'b1;
      #1;

      // R-type
      chk("r_fetch", State, 4'd0);
      chk("r_irwrite", IRWrite, 1'b1);
      chk("r_pcen", PCEn, 1'b1);
      chk("r_memread", MemRead, 1'b1);
      chk("r_alusrcb_f", ALUSrcB, 2'b01);
      tick();
      chk("r_decode", State, 4'd1);
      chk("r_alusrcb_d", ALUSrcB, 2'b11);
      tick();
      chk("r_exec", State, 4'd6);
      chk("r_aluop", ALUOp, 2'b10);
      chk("r_exec_regwr", RegWrite, 1'b0);
      tick();
      chk("r_aluwb", State, 4'd7);
      chk("r_regwrite", RegWrite, 1'b1);
      chk("r_regdst", RegDst, 1'b1);
      tick();
      chk("r_back", State, 4'd0);
      chk("r_retire", Retire, 1'b1);
      chk("r_count", InstrCount, 4'd1);

      // Fetch stall
      MemReady = 1'b0;
      #1;
      chk("stall_irwrite", IRWrite, 1'b0);
      chk("stall_pcen", PCEn, 1'b0);
      tick();
      chk("stall_state", State, 4'd0);
      chk("stall_retire", Retire, 1'b0);
      MemReady = 1'b1;
      Opcode   = 6'b100011;

      // lw with 3 wait cycles
      tick();
      chk("lw_decode", State, 4'd1);
      tick();
      chk("lw_memadr", State, 4'd2);
      chk("lw_srca", ALUSrcA, 1'b1);
      chk("lw_srcb", ALUSrcB, 2'b10);
      MemReady = 1'b0;
      tick();
      chk("lw_memrd1", State, 4'd3);
      chk("lw_memread", MemRead, 1'b1);
      chk("lw_iord", IorD, 1'b1);
      tick();
      chk("lw_memrd2", State, 4'd3);
      tick();
      chk("lw_memrd3", State, 4'd3);
      tick();
      chk("lw_memrd4", State, 4'd3);
      MemReady = 1'b1;
      tick();
      chk("lw_memwb", State, 4'd4);
      chk("lw_regwrite", RegWrite, 1'b1);
      chk("lw_memtoreg", MemtoReg, 1'b1);
      chk("lw_regdst", RegDst, 1'b0);
      chk("lw_wb_retire", Retire, 1'b0);
      tick();
      chk("lw_back", State, 4'd0);
      chk("lw_retire", Retire, 1'b1);
      chk("lw_count", InstrCount, 4'd2);

      // beq taken then not taken
      Opcode = 6'b000100;
      Zero   = 1'b1;
      tick();
      chk("beq1_decode", State, 4'd1);
      tick();
      chk("beq1_state", State, 4'd8);
      chk("beq1_pcen", PCEn, 1'b1);
      chk("beq1_pcsrc", PCSource, 2'b01);
      chk("beq1_aluop", ALUOp, 2'b01);
      tick();
      chk("beq1_retire", Retire, 1'b1);
      chk("beq1_count", InstrCount, 4'd3);
      Zero = 1'b0;
      tick();
      chk("beq2_decode", State, 4'd1);
      tick();
      chk("beq2_state", State, 4'd8);
      chk("beq2_pcen", PCEn, 1'b0);
      tick();
      chk("beq2_retire", Retire, 1'b1);
      chk("beq2_count", InstrCount, 4'd4);

      // illegal opcode on both instances
      Opcode = 6'b111111;
      tick();
      chk("ill_decode", State, 4'd1);
      tick();
      chk("ill_state", State, 4'd0);
      chk("ill_pulse", Illegal, 1'b1);
      chk("ill_noretire", Retire, 1'b0);
      chk("ill_count", InstrCount, 4'd4);
      chk("trap_state", t_State, 4'd15);
      chk("trap_pulse", t_Illegal, 1'b1);
      chk("trap_count", t_InstrCount, 8'd4);
      Opcode = 6'b101011;
      tick();
      chk("ill_pulse_end", Illegal, 1'b0);
      chk("ill_next", State, 4'd1);
      chk("trap_hold", t_State, 4'd15);
      chk("trap_pulse_end", t_Illegal, 1'b0);
      chk("trap_memread", t_MemRead, 1'b0);
      chk("trap_pcen", t_PCEn, 1'b0);

      // sw with one wait cycle
      tick();
      chk("sw_memadr", State, 4'd2);
      MemReady = 1'b0;
      tick();
      chk("sw_memwr1", State, 4'd5);
      chk("sw_memwrite", MemWrite, 1'b1);
      chk("sw_memread", MemRead, 1'b0);
      chk("sw_iord", IorD, 1'b1);
      tick();
      chk("sw_memwr2", State, 4'd5);
      chk("sw_wait_retire", Retire, 1'b0);
      MemReady = 1'b1;
      tick();
      chk("sw_back", State, 4'd0);
      chk("sw_retire", Retire, 1'b1);
      chk("sw_count", InstrCount, 4'd5);

      // reset mid MEMWR wait
      tick();
      chk("swr_decode", State, 4'd1);
      tick();
      chk("swr_memadr", State, 4'd2);
      MemReady = 1'b0;
      tick();
      chk("swr_memwr", State, 4'd5);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("arst_state", State, 4'd0);
      chk("arst_count", InstrCount, 4'd0);
      chk("arst_memwrite", MemWrite, 1'b0);
      chk("arst_retire", Retire, 1'b0);
      chk("arst_trap_state", t_State, 4'd0);
      @(negedge Clk);
      Reset_n  = 1'b1;
      MemReady = 1'b1;
      Opcode   = 6'b000010;
      #1;
      chk("arst_after", State, 4'd0);
      chk("arst_after_retire", Retire, 1'b0);

      // 16 jumps wrap the 4-bit counter
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("j_decode", State, 4'd1);
         tick();
         chk("j_state", State, 4'd9);
         chk("j_pcen", PCEn, 1'b1);
         chk("j_pcsrc", PCSource, 2'b10);
         tick();
         chk("j_retire", Retire, 1'b1);
         chk("j_count", InstrCount, 32'(i % 16));
      end

      // addi
      Opcode = 6'b001000;
      tick();
      chk("addi_decode", State, 4'd1);
      tick();
      chk("addi_ex", State, 4'd10);
      chk("addi_srcb", ALUSrcB, 2'b10);
      chk("addi_srca", ALUSrcA, 1'b1);
      tick();
      chk("addi_wb", State, 4'd11);
      chk("addi_regwrite", RegWrite, 1'b1);
      chk("addi_regdst", RegDst, 1'b0);
      chk("addi_memtoreg", MemtoReg, 1'b0);
      tick();
      chk("addi_retire", Retire, 1'b1);
      chk("addi_count", InstrCount, 4'd1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
